// File: rtl/piso_frame_shifter.sv
// Parallel-in/serial-out frame shifter for a UART transmit datapath.
// Optional build macro SHIFT_PARITY_EN appends a parity bit after the data bits.
module piso_frame_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  input  logic                  SHIFT,
  output logic                  DATA_OUT,
  output logic                  BUSY,
  output logic                  DONE
`ifdef SHIFT_PARITY_EN
  ,
  input  logic                  PARITY_ODD
`endif
);

`ifdef SHIFT_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = DATA_WIDTH + PAR_BITS;
  localparam int CW    = $clog2(NBITS + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SHIFTING = 1'b1;

  // The shift register always presents its head at bit 0; bit order is resolved at load.
  function automatic logic [DATA_WIDTH-1:0] order_bits(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        r[i] = d[DATA_WIDTH-1-i];
      end
    end else begin
      r = d;
    end
    return r;
  endfunction

`ifdef SHIFT_PARITY_EN
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  logic [0:0]       state_r,    state_s;
  logic [NBITS-1:0] shreg_r,    shreg_s;
  logic [CW-1:0]    count_r,    count_s;
  logic             data_out_r, data_out_s;
  logic             done_r,     done_s;
  logic [NBITS-1:0] load_word_s;

  // Word as it will be sent: data in send order, parity (if any) in the top position.
  always_comb begin
`ifdef SHIFT_PARITY_EN
    load_word_s = {calc_parity(DATA_IN, PARITY_ODD), order_bits(DATA_IN)};
`else
    load_word_s = order_bits(DATA_IN);
`endif
  end

  // Next-state logic for the frame controller and datapath.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    count_s    = count_r;
    data_out_s = data_out_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        data_out_s = IDLE_LEVEL;
        if (LOAD_VALID) begin
          state_s    = ST_SHIFTING;
          shreg_s    = load_word_s;
          count_s    = CW'(NBITS);
          data_out_s = load_word_s[0];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFTING: begin
        if (SHIFT) begin
          if (count_r == CW'(1)) begin
            state_s    = ST_IDLE;
            shreg_s    = '0;
            count_s    = '0;
            data_out_s = IDLE_LEVEL;
            done_s     = 1'b1;
          end else begin
            shreg_s    = shreg_r >> 1;
            count_s    = count_r - CW'(1);
            data_out_s = shreg_r[1];
          end
        end else begin
          state_s = ST_SHIFTING;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        shreg_s    = '0;
        count_s    = '0;
        data_out_s = IDLE_LEVEL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      count_r    <= '0;
      data_out_r <= IDLE_LEVEL;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      count_r    <= count_s;
      data_out_r <= data_out_s;
      done_r     <= done_s;
    end
  end

  assign BUSY       = (state_r == ST_SHIFTING);
  assign LOAD_READY = ~BUSY;
  assign DATA_OUT   = data_out_r;
  assign DONE       = done_r;

endmodule

// File: tb/tb_piso_frame_shifter.sv
// Directed bench: an LSB-first and an MSB-first shifter share stimulus; vector table plus corner sequences.
module tb_piso_frame_shifter;

`ifdef SHIFT_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DATA_IN;
  logic       LOAD_VALID;
  logic       SHIFT;
  logic       PARITY_ODD;
  logic       ready_l, out_l, busy_l, done_l;
  logic       ready_m, out_m, busy_m, done_m;
  int         n_cmp  = 0;
  int         n_fail = 0;

  piso_frame_shifter #(.DATA_WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID), .LOAD_READY(ready_l),
    .SHIFT(SHIFT), .DATA_OUT(out_l), .BUSY(busy_l), .DONE(done_l)
`ifdef SHIFT_PARITY_EN
    , .PARITY_ODD(PARITY_ODD)
`endif
  );

  piso_frame_shifter #(.DATA_WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_msb (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID), .LOAD_READY(ready_m),
    .SHIFT(SHIFT), .DATA_OUT(out_m), .BUSY(busy_m), .DONE(done_m)
`ifdef SHIFT_PARITY_EN
    , .PARITY_ODD(PARITY_ODD)
`endif
  );

  always #5 CLK = ~CLK;

  // seq: expected data bits in send order, first bit at seq[7]; par: parity bit for PARITY_ODD=0
  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] seq;
    logic       par;
    int         gap;
    logic       inject;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic msb, input logic exp_out,
                             input logic exp_busy, input logic exp_done);
    check({name, ".out"},   msb ? out_m   : out_l,   exp_out);
    check({name, ".busy"},  msb ? busy_m  : busy_l,  exp_busy);
    check({name, ".ready"}, msb ? ready_m : ready_l, ~exp_busy);
    check({name, ".done"},  msb ? done_m  : done_l,  exp_done);
  endtask

  task automatic load(input logic [7:0] d, input logic with_shift);
    DATA_IN    = d;
    LOAD_VALID = 1'b1;
    SHIFT      = with_shift;
    step();
    LOAD_VALID = 1'b0;
    SHIFT      = 1'b0;
    DATA_IN    = 8'h00;
  endtask

  // Shift out one loaded frame; ends in the DONE cycle.
  task automatic shift_out(input string name, input logic msb, input logic [7:0] seq,
                           input logic par, input int gap, input logic inject);
    logic b;
    for (int i = 0; i < NB; i++) begin
      b = (i < 8) ? seq[7-i] : par;
      check_state($sformatf("%s.bit%0d", name, i), msb, b, 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) begin
        if (inject) begin
          DATA_IN    = 8'hFF;
          LOAD_VALID = 1'b1;
        end else begin
          LOAD_VALID = 1'b0;
        end
        step();
        check_state($sformatf("%s.hold%0d", name, i), msb, b, 1'b1, 1'b0);
      end
      LOAD_VALID = 1'b0;
      DATA_IN    = 8'h00;
      SHIFT      = 1'b1;
      step();
      SHIFT      = 1'b0;
    end
    check_state({name, ".end"}, msb, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hC1, msb: 1'b0, seq: 8'b10000011, par: 1'b1, gap: 0, inject: 1'b0};
    vecs[1] = '{data: 8'hC1, msb: 1'b1, seq: 8'b11000001, par: 1'b1, gap: 3, inject: 1'b1};
    vecs[2] = '{data: 8'hA5, msb: 1'b0, seq: 8'b10100101, par: 1'b0, gap: 1, inject: 1'b0};
    vecs[3] = '{data: 8'h6D, msb: 1'b1, seq: 8'b01101101, par: 1'b1, gap: 1, inject: 1'b1};
    vecs[4] = '{data: 8'h6D, msb: 1'b0, seq: 8'b10110110, par: 1'b1, gap: 0, inject: 1'b0};
    vecs[5] = '{data: 8'h0F, msb: 1'b1, seq: 8'b00001111, par: 1'b0, gap: 0, inject: 1'b0};

    RST = 1'b1; LOAD_VALID = 1'b1; SHIFT = 1'b1; DATA_IN = 8'hAA; PARITY_ODD = 1'b0;

    // Reset has priority over load and shift
    step();
    check_state("rst1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_state("rst2", 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("rst2m", 1'b1, 1'b1, 1'b0, 1'b0);
    RST = 1'b0; LOAD_VALID = 1'b0; SHIFT = 1'b1;
    step();
    check_state("post_rst_shift_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    SHIFT = 1'b0;

    foreach (vecs[k]) begin
      load(vecs[k].data, 1'b0);
      shift_out($sformatf("vec%0d", k), vecs[k].msb, vecs[k].seq, vecs[k].par,
                vecs[k].gap, vecs[k].inject);
      step();
      check_state($sformatf("vec%0d.after", k), vecs[k].msb, 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back: second load in the DONE cycle, with SHIFT asserted (load wins)
    load(8'h0F, 1'b0);
    shift_out("b2b_a", 1'b0, 8'b11110000, 1'b0, 0, 1'b0);
    load(8'hF0, 1'b1);
    shift_out("b2b_b", 1'b0, 8'b00001111, 1'b0, 0, 1'b0);
    step();
    check_state("b2b.after", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame aborts without DONE
    load(8'hC1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      SHIFT = 1'b1;
      step();
    end
    SHIFT = 1'b0;
    check_state("abort.pre", 1'b0, 1'b0, 1'b1, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_state("abort.rst", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_state("abort.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    load(8'h01, 1'b0);
    shift_out("abort.next", 1'b0, 8'b10000000, 1'b1, 0, 1'b0);
    step();
    check_state("abort.next.after", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SHIFT_PARITY_EN
    // Odd parity sense inverts the ninth bit
    PARITY_ODD = 1'b1;
    load(8'hC1, 1'b0);
    PARITY_ODD = 1'b0;
    shift_out("par_odd", 1'b0, 8'b10000011, 1'b0, 0, 1'b0);
    step();
    check_state("par_odd.after", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
